// File: rtl/conv_channel_sum_join.sv
// N-channel join: per-channel FIFOs, aligned pop, sum + bias, saturate, optional ReLU.
// Build option: CONV_SUM_SATCNT_EN enables the saturating sat_count counter.
module conv_channel_sum_join #(
  parameter int unsigned CH         = 3,
  parameter int unsigned Datawidth  = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int          BIAS       = 0,
  parameter bit          ReLU       = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH-1:0]           in_valid,
  input  logic [CH*Datawidth-1:0] in_data,
  output logic [CH-1:0]           in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [Datawidth-1:0]    out_data,
  output logic                    sat_sticky,
  output logic [15:0]             sat_count
);

  localparam int unsigned DW = Datawidth;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = DW + $clog2(CH + 1) + 1;
  localparam logic [CW-1:0]        DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic signed [DW-1:0] BIAS_W  = DW'(BIAS);
  localparam logic signed [SW-1:0] MAXV    = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV    = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic [DW-1:0] mem_q [CH][FIFO_DEPTH];
  logic [AW-1:0] wptr_q [CH];
  logic [AW-1:0] wptr_d [CH];
  logic [AW-1:0] rptr_q [CH];
  logic [AW-1:0] rptr_d [CH];
  logic [CW-1:0] cnt_q  [CH];
  logic [CW-1:0] cnt_d  [CH];
  logic [CW-1:0] vis_q  [CH];
  logic [CW-1:0] vis_d  [CH];
  logic [CH-1:0] pend_q, pend_d;
  logic [CH-1:0] full_c, nonempty_c, push_c;

  logic              en_c, fire_c, sat_evt_c;
  logic signed [SW-1:0] sum_c;
  logic [DW-1:0]     clamp_c;
  logic              s1_valid_q, s1_valid_d;
  logic signed [SW-1:0] s1_sum_q, s1_sum_d;
  logic              out_valid_q, out_valid_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              sat_sticky_q, sat_sticky_d;

  assign in_ready   = {CH{rst}} & ~full_c;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign sat_sticky = sat_sticky_q;

  // FIFO bookkeeping: cnt tracks occupancy (for ready), vis lags pushes by one cycle (for pop)
  always_comb begin
    for (int unsigned c = 0; c < CH; c++) begin
      full_c[c]     = (cnt_q[c] == DEPTH_C);
      nonempty_c[c] = (vis_q[c] != '0);
    end
    push_c = in_valid & in_ready;
    en_c   = !out_valid_q || out_ready;
    fire_c = en_c && (&nonempty_c);
    pend_d = push_c;
    for (int unsigned c = 0; c < CH; c++) begin
      wptr_d[c] = wptr_q[c] + AW'(push_c[c]);
      rptr_d[c] = rptr_q[c] + AW'(fire_c);
      cnt_d[c]  = cnt_q[c] + CW'(push_c[c]) - CW'(fire_c);
      vis_d[c]  = vis_q[c] + CW'(pend_q[c]) - CW'(fire_c);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < CH; c++) begin
      if (push_c[c]) mem_q[c][wptr_q[c]] <= in_data[c*DW +: DW];
    end
  end

  // Full-width sum of all heads plus bias; cannot wrap at SW bits
  always_comb begin
    sum_c = SW'(BIAS_W);
    for (int unsigned c = 0; c < CH; c++) begin
      sum_c = sum_c + SW'($signed(mem_q[c][rptr_q[c]]));
    end
  end

  always_comb begin
    sat_evt_c = en_c && s1_valid_q && ((s1_sum_q > MAXV) || (s1_sum_q < MINV));
    if (s1_sum_q > MAXV)      clamp_c = DW'(MAXV);
    else if (s1_sum_q < MINV) clamp_c = DW'(MINV);
    else                      clamp_c = DW'(s1_sum_q);
    if (ReLU && clamp_c[DW-1]) clamp_c = '0;
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_sum_d     = s1_sum_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    sat_sticky_d = sat_sticky_q | sat_evt_c;
    if (en_c) begin
      s1_valid_d  = fire_c;
      s1_sum_d    = sum_c;
      out_valid_d = s1_valid_q;
      out_data_d  = clamp_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned c = 0; c < CH; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
        vis_q[c]  <= '0;
      end
      pend_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_sum_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      sat_sticky_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < CH; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        cnt_q[c]  <= cnt_d[c];
        vis_q[c]  <= vis_d[c];
      end
      pend_q       <= pend_d;
      s1_valid_q   <= s1_valid_d;
      s1_sum_q     <= s1_sum_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

`ifdef CONV_SUM_SATCNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Counts saturation events, sticking at all-ones
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_evt_c && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) sat_cnt_q <= '0;
    else      sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;
`else
  assign sat_count = 16'd0;
`endif

endmodule

// File: tb/tb_conv_channel_sum_join.sv
// Randomised bench for conv_channel_sum_join: two instances (plain, and bias+ReLU) against a queue model.
module tb_conv_channel_sum_join;

  localparam int CH = 3;
  localparam int DW = 16;
  localparam int BIAS_B = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [CH-1:0]    in_valid;
  logic [CH*DW-1:0] in_data;
  logic             out_ready;
  logic [CH-1:0]    in_ready_a, in_ready_b;
  logic             out_valid_a, out_valid_b;
  logic [DW-1:0]    out_data_a, out_data_b;
  logic             sat_sticky_a, sat_sticky_b;
  logic [15:0]      sat_count_a, sat_count_b;

  conv_channel_sum_join #(.CH(CH), .Datawidth(DW), .FIFO_DEPTH(4), .BIAS(0), .ReLU(1'b0)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .sat_sticky(sat_sticky_a), .sat_count(sat_count_a));

  conv_channel_sum_join #(.CH(CH), .Datawidth(DW), .FIFO_DEPTH(4), .BIAS(BIAS_B), .ReLU(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .sat_sticky(sat_sticky_b), .sat_count(sat_count_b));

  int errors = 0;
  int checks = 0;

  int chq [CH][$];
  int expa[$];
  int expb[$];
  int sata = 0;
  int satb = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampf(input longint s, input bit relu);
    longint r;
    r = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
    if (relu && r < 0) r = 0;
    return int'(r);
  endfunction

  function automatic bit satf(input longint s);
    return (s > 32767) || (s < -32768);
  endfunction

  // Pair words strictly by per-channel arrival order
  function automatic void pair();
    while (chq[0].size() > 0 && chq[1].size() > 0 && chq[2].size() > 0) begin
      longint s = 0;
      for (int c = 0; c < CH; c++) s += chq[c].pop_front();
      expa.push_back(clampf(s, 1'b0));
      if (satf(s)) sata++;
      expb.push_back(clampf(s + BIAS_B, 1'b1));
      if (satf(s + BIAS_B)) satb++;
    end
  endfunction

  // One clock: check the presented output, record pushes, advance past the edge
  task automatic tick();
    logic [CH-1:0] pv;
    pv = in_valid & in_ready_a;
    if (rst && out_valid_a) begin
      if (expa.size() == 0) check("spurious_out", out_valid_a, 0);
      else begin
        check("data_a", $signed(out_data_a), expa[0]);
        check("data_b", $signed(out_data_b), expb[0]);
        check("valid_b", out_valid_b, 1);
        if (out_ready) begin
          void'(expa.pop_front());
          void'(expb.pop_front());
        end
      end
    end
    if (rst) begin
      for (int c = 0; c < CH; c++)
        if (pv[c]) chq[c].push_back(int'($signed(in_data[c*DW +: DW])));
    end
    @(posedge clk);
    #1;
    pair();
  endtask

  task automatic drive(input logic [CH-1:0] v, input int d0, input int d1, input int d2);
    in_valid = v;
    in_data  = {16'(d2), 16'(d1), 16'(d0)};
    tick();
    in_valid = '0;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    tick();
    for (int c = 0; c < CH; c++) chq[c].delete();
    expa.delete();
    expb.delete();
    sata = 0;
    satb = 0;
    check("rst_valid", out_valid_a, 0);
    check("rst_data", out_data_a, 0);
    check("rst_sticky", sat_sticky_a, 0);
    check("rst_count", sat_count_a, 0);
    check("rst_ready_low", in_ready_a, 0);
    rst = 1'b1;
    #1;
    check("rst_ready_rel", in_ready_a, 3'b111);
    check("rst_ready_rel_b", in_ready_b, 3'b111);
    out_ready = 1'b1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = '0;
    for (int i = 0; i < 100 && (expa.size() != 0 || out_valid_a); i++) tick();
    check("drain_left", expa.size(), 0);
    check("drain_valid", out_valid_a, 0);
    check("sticky_a", sat_sticky_a, sata > 0);
    check("sticky_b", sat_sticky_b, satb > 0);
`ifdef CONV_SUM_SATCNT_EN
    check("satcnt_a", sat_count_a, (sata > 65535) ? 65535 : sata);
    check("satcnt_b", sat_count_b, (satb > 65535) ? 65535 : satb);
`else
    check("satcnt_a", sat_count_a, 0);
    check("satcnt_b", sat_count_b, 0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Latency: word pushed at edge t appears after edge t+3
    drive(3'b111, 10, 20, 30);
    tick(); check("lat_t1", out_valid_a, 0);
    tick(); check("lat_t2", out_valid_a, 0);
    tick(); check("lat_t3", out_valid_a, 1);
    check("lat_data_a", out_data_a, 60);
    check("lat_data_b", out_data_b, 65);
    drain();

    // Skew: channel 0 runs four words ahead and fills its FIFO
    for (int i = 1; i <= 4; i++) drive(3'b001, i, 0, 0);
    check("skew_rdy0", in_ready_a[0], 0);
    check("skew_rdy1", in_ready_a[1], 1);
    check("skew_noout", out_valid_a, 0);
    for (int i = 1; i <= 4; i++) drive(3'b110, 0, i, i);
    drain();

    // ReLU and sign handling, no saturation
    do_reset();
    drive(3'b111, -9, 2, 1);
    drive(3'b111, 5, 2, 1);
    drain();

    // Saturation both directions
    drive(3'b111, 30000, 30000, 30000);
    drain();
    drive(3'b111, -30000, -30000, -30000);
    drain();

    // Backpressure: outputs held, FIFOs fill and stall inputs
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 3'b111;
      for (int c = 0; c < CH; c++) in_data[c*DW +: DW] = 16'($urandom_range(0, 2000) - 1000);
      tick();
      if (i >= 3) check("bp_valid", out_valid_a, 1);
    end
    check("bp_ready_a", in_ready_a, 0);
    check("bp_ready_b", in_ready_b, 0);
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 1500; i++) begin
      in_valid  = CH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < CH; c++)
        in_data[c*DW +: DW] = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 200) - 100);
      tick();
    end
    drain();

    // Reset mid-stream with output held and FIFOs partly full
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) drive(3'b111, 100 * i, 1, 1);
    tick();
    check("mid_valid_pre", out_valid_a, 1);
    do_reset();
    drive(3'b111, 7, 8, 9);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
